// File: rtl/pipelined_data_mem.sv
// rtl/pipelined_data_mem.sv - byte-strobed data memory with fixed-latency valid/ready response pipeline
module pipelined_data_mem #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                DEPTH        = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [15:0]         err_count
);
    localparam int NB    = DATA_W / 8;
    localparam int SH    = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int L     = READ_LATENCY;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NB - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);

    logic [7:0] mem [DEPTH][NB];

    logic [L-1:0]             stg_valid;
    logic [L-1:0][DATA_W-1:0] stg_rdata;
    logic [L-1:0]             stg_err;

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic              misaligned;
    logic              out_of_range;
    logic              req_err;
    logic              advance;
    logic              accept;
    logic [DATA_W-1:0] rd_word;

    always_comb begin
        offset       = req_addr - BASE_ADDR;
        word         = offset >> SH;
        idx          = word[IDX_W-1:0];
        misaligned   = |(req_addr & ALIGN_MASK);
        out_of_range = (req_addr < BASE_ADDR) || (word >= DEPTH_A);
        req_err      = misaligned || out_of_range;
        advance      = !stg_valid[L-1] || resp_ready;
        // Requests presented during reset are not taken, so they cannot touch memory.
        accept       = req_valid && advance && !reset;
    end

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < NB; b++) begin
            rd_word[8*b +: 8] = mem[idx][b];
        end
    end

    // Array has no reset so committed writes survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (accept && req_write && !req_err) begin
            for (int b = 0; b < NB; b++) begin
                if (req_wstrb[b]) begin
                    mem[idx][b] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid <= '0;
            stg_rdata <= '0;
            stg_err   <= '0;
        end else if (advance) begin
            stg_valid[0] <= accept;
            stg_rdata[0] <= (accept && !req_write && !req_err) ? rd_word : '0;
            stg_err[0]   <= accept && req_err;
            for (int i = 1; i < L; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_rdata[i] <= stg_rdata[i-1];
                stg_err[i]   <= stg_err[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (accept && req_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

    assign req_ready  = advance;
    assign resp_valid = stg_valid[L-1];
    assign resp_rdata = stg_rdata[L-1];
    assign resp_err   = stg_err[L-1];
endmodule
